// File: rtl/xnor_match_unit.sv
// -----------------------------------------------------------------------------
// xnor_match_unit
//
// Applies a selectable bitwise function (XNOR, XOR, NOR, NAND) to two WIDTH-bit
// operands and registers the result. It then counts the ones in the result
// serially, CHUNK bits per cycle, and flags an all-ones result. For XNOR, an
// all-ones result means a == b. Valid/ready handshakes are used on both the
// producer and consumer sides.
//
// Parameters:
//   WIDTH  operand/result width (>= 1)
//   CHUNK  result bits counted per cycle (WIDTH must be a multiple of CHUNK)
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous reset, active low
//   in_valid   in   a, b and mode are valid
//   in_ready   out  unit is idle and can accept a transaction
//   a, b       in   WIDTH-bit operands
//   mode       in   00 XNOR, 01 XOR, 10 NOR, 11 NAND
//   out_valid  out  result, count and all_ones are valid
//   out_ready  in   consumer accepts the result
//   result     out  registered op(a, b)
//   count      out  number of ones in result ($clog2(WIDTH+1) bits)
//   all_ones   out  result is all ones (meaningful while out_valid)
//
// Optional feature, enabled by defining XNOR_MATCH_ACCUM_EN:
//   accum_clr  in   synchronous clear of accum (wins over a same-edge add)
//   accum      out  16-bit saturating running sum of count over completed
//                   transactions
// -----------------------------------------------------------------------------
module xnor_match_unit #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           a,
    input  logic [WIDTH-1:0]           b,
    input  logic [1:0]                 mode,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           result,
    output logic [$clog2(WIDTH+1)-1:0] count,
`ifdef XNOR_MATCH_ACCUM_EN
    input  logic                       accum_clr,
    output logic [15:0]                accum,
`endif
    output logic                       all_ones
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int CW     = $clog2(WIDTH + 1);

    localparam logic [IW-1:0] LAST_IDX   = IW'(NCHUNK - 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        OP_XNOR = 2'b00,
        OP_XOR  = 2'b01,
        OP_NOR  = 2'b10,
        OP_NAND = 2'b11
    } op_e;

    generate
        if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
            $error("xnor_match_unit: WIDTH must be >= 1 and a multiple of CHUNK");
        end
    endgenerate

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CW-1:0]    count_q, count_d;
    logic [IW-1:0]    idx_q, idx_d;

    logic [WIDTH-1:0] op_result;
    logic [CHUNK-1:0] chunk_bits;
    logic [CW-1:0]    chunk_pop;
    logic             handshake_out;

    // ------------------------------------------------------------------
    // Bitwise function of the operands. It is only consumed on the
    // accepting edge, so later changes to a/b/mode cannot leak in.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        op_result = '0;
        case (op_e'(mode))
            OP_XNOR: op_result = ~(a ^ b);
            OP_XOR:  op_result = a ^ b;
            OP_NOR:  op_result = ~(a | b);
            OP_NAND: op_result = ~(a & b);
            default: op_result = ~(a ^ b);
        endcase
    end

    // Popcount of the chunk selected by idx_q (LSB chunk first).
    always_comb begin
        chunk_bits = result_q[int'(idx_q) * CHUNK +: CHUNK];
        chunk_pop  = '0;
        for (int i = 0; i < CHUNK; i++) begin
            chunk_pop = chunk_pop + CW'(chunk_bits[i]);
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every
            // register samples its pre-edge inputs regardless of block order.
            state_q <= state_d;
        end
    end

    // FSM: next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid)           state_d = S_BUSY;
            S_BUSY:  if (idx_q == LAST_IDX)  state_d = S_DONE;
            S_DONE:  if (out_ready)          state_d = S_IDLE;
            default:                         state_d = S_IDLE;
        endcase
    end

    // FSM: outputs. all_ones is qualified by DONE so that it reads 0 out of
    // reset and while a count is still accumulating.
    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
        all_ones  = (state_q == S_DONE) && (count_q == FULL_COUNT);
    end

    assign handshake_out = (state_q == S_DONE) && out_ready;

    // ------------------------------------------------------------------
    // Datapath: result capture and serial ones count
    // ------------------------------------------------------------------
    always_comb begin
        result_d = result_q;
        count_d  = count_q;
        idx_d    = idx_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    result_d = op_result;
                    count_d  = '0;
                    idx_d    = '0;
                end
            end
            S_BUSY: begin
                count_d = count_q + chunk_pop;
                idx_d   = idx_q + 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            count_q  <= '0;
            idx_q    <= '0;
        end else begin
            result_q <= result_d;
            count_q  <= count_d;
            idx_q    <= idx_d;
        end
    end

    assign result = result_q;
    assign count  = count_q;

`ifdef XNOR_MATCH_ACCUM_EN
    // ------------------------------------------------------------------
    // Running sum of count over completed transactions, saturating.
    // ------------------------------------------------------------------
    logic [15:0] accum_q, accum_d;
    logic [16:0] accum_sum;

    assign accum_sum = {1'b0, accum_q} + 17'(count_q);

    always_comb begin
        accum_d = accum_q;
        if (accum_clr) begin
            accum_d = '0;
        end else if (handshake_out) begin
            accum_d = accum_sum[16] ? 16'hFFFF : accum_sum[15:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            accum_q <= '0;
        end else begin
            accum_q <= accum_d;
        end
    end

    assign accum = accum_q;
`else
    logic unused_handshake;
    assign unused_handshake = handshake_out;
`endif

endmodule

// File: tb/tb_xnor_match_unit.sv
// -----------------------------------------------------------------------------
// Testbench for xnor_match_unit.
// dut8: WIDTH=8, CHUNK=1. dut4: WIDTH=8, CHUNK=4.
// Stimulus pushes hand-computed expectations into a queue per DUT; a monitor
// per DUT pops and compares on each output handshake.
// -----------------------------------------------------------------------------
module tb_xnor_match_unit;

    typedef struct {
        logic [7:0] res;
        int         cnt;
        logic       ao;
        int         acc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;

    // dut8 signals
    logic       in_valid, in_ready, out_valid, out_ready, all_ones;
    logic [7:0] a, b, result;
    logic [1:0] mode;
    logic [3:0] count;
    logic       accum_clr;
    logic [15:0] accum;

    // dut4 signals
    logic       in_valid_4, in_ready_4, out_valid_4, out_ready_4, all_ones_4;
    logic [7:0] a_4, b_4, result_4;
    logic [1:0] mode_4;
    logic [3:0] count_4;
    logic       accum_clr_4;
    logic [15:0] accum_4;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    exp_t exp_q[$];
    exp_t exp4_q[$];
    exp_t e8, e4;
    logic ov_prev = 1'b0;
    logic ov_prev_4 = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    xnor_match_unit #(.WIDTH(8), .CHUNK(1)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .count     (count),
`ifdef XNOR_MATCH_ACCUM_EN
        .accum_clr (accum_clr),
        .accum     (accum),
`endif
        .all_ones  (all_ones)
    );

    xnor_match_unit #(.WIDTH(8), .CHUNK(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid_4),
        .in_ready  (in_ready_4),
        .a         (a_4),
        .b         (b_4),
        .mode      (mode_4),
        .out_valid (out_valid_4),
        .out_ready (out_ready_4),
        .result    (result_4),
        .count     (count_4),
`ifdef XNOR_MATCH_ACCUM_EN
        .accum_clr (accum_clr_4),
        .accum     (accum_4),
`endif
        .all_ones  (all_ones_4)
    );

`ifndef XNOR_MATCH_ACCUM_EN
    assign accum   = 16'h0;
    assign accum_4 = 16'h0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitors: compare on each output handshake, check latency on rise.
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (!rst_n) begin
            ov_prev = 1'b0;
        end else begin
            if (out_valid && !ov_prev) begin
                if (exp_q.size() == 0) check("spurious_out_valid", 32'(out_valid), 32'd0);
                else                   check("latency_c1", 32'(cyc - exp_q[0].acc), 32'd8);
            end
            if (out_valid) check("in_ready_in_done", 32'(in_ready), 32'd0);
            if (out_valid && out_ready && exp_q.size() > 0) begin
                e8 = exp_q.pop_front();
                check("result", 32'(result), 32'(e8.res));
                check("count", 32'(count), 32'(e8.cnt));
                check("all_ones", 32'(all_ones), 32'(e8.ao));
            end
            ov_prev = out_valid;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            ov_prev_4 = 1'b0;
        end else begin
            if (out_valid_4 && !ov_prev_4) begin
                if (exp4_q.size() == 0) check("spurious_out_valid_c4", 32'(out_valid_4), 32'd0);
                else                    check("latency_c4", 32'(cyc - exp4_q[0].acc), 32'd2);
            end
            if (out_valid_4 && out_ready_4 && exp4_q.size() > 0) begin
                e4 = exp4_q.pop_front();
                check("result_c4", 32'(result_4), 32'(e4.res));
                check("count_c4", 32'(count_4), 32'(e4.cnt));
                check("all_ones_c4", 32'(all_ones_4), 32'(e4.ao));
            end
            ov_prev_4 = out_valid_4;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers. Called just after a rising edge.
    // ------------------------------------------------------------------
    task automatic send(input logic [7:0] ta, input logic [7:0] tb, input logic [1:0] tm,
                        input logic [7:0] er, input int ec, input logic eo);
        int n = 0;
        while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
        check("send_wait_in_ready", 32'(in_ready), 32'd1);
        a = ta; b = tb; mode = tm; in_valid = 1'b1;
        @(posedge clk); #1;
        exp_q.push_back('{res: er, cnt: ec, ao: eo, acc: cyc});
        in_valid = 1'b0;
        // Scramble operands: the transaction in flight must ignore them.
        a = 8'($urandom); b = 8'($urandom); mode = 2'($urandom);
    endtask

    task automatic send4(input logic [7:0] ta, input logic [7:0] tb, input logic [1:0] tm,
                         input logic [7:0] er, input int ec, input logic eo);
        int n = 0;
        while (!in_ready_4 && n < 100) begin @(posedge clk); #1; n++; end
        check("send4_wait_in_ready", 32'(in_ready_4), 32'd1);
        a_4 = ta; b_4 = tb; mode_4 = tm; in_valid_4 = 1'b1;
        @(posedge clk); #1;
        exp4_q.push_back('{res: er, cnt: ec, ao: eo, acc: cyc});
        in_valid_4 = 1'b0;
        a_4 = 8'($urandom); b_4 = 8'($urandom); mode_4 = 2'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (!(exp_q.size() == 0 && in_ready) && n < 200) begin @(posedge clk); #1; n++; end
        check("drain_pending", 32'(exp_q.size()), 32'd0);
        check("drain_in_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic drain4();
        int n = 0;
        while (!(exp4_q.size() == 0 && in_ready_4) && n < 200) begin @(posedge clk); #1; n++; end
        check("drain4_pending", 32'(exp4_q.size()), 32'd0);
        check("drain4_in_ready", 32'(in_ready_4), 32'd1);
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        int n;
        logic seen;

        rst_n = 1'b0;
        in_valid = 1'b0; a = '0; b = '0; mode = '0; out_ready = 1'b1; accum_clr = 1'b0;
        in_valid_4 = 1'b0; a_4 = '0; b_4 = '0; mode_4 = '0; out_ready_4 = 1'b1; accum_clr_4 = 1'b0;

        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_all_ones", 32'(all_ones), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Function table, hand-computed.
        send(8'hA5, 8'hA5, 2'b00, 8'hFF, 8, 1'b1);
        send(8'h0F, 8'h00, 2'b00, 8'hF0, 4, 1'b0);
        send(8'hFF, 8'h0F, 2'b01, 8'hF0, 4, 1'b0);
        send(8'h01, 8'h02, 2'b10, 8'hFC, 6, 1'b0);
        send(8'hFF, 8'hFF, 2'b11, 8'h00, 0, 1'b0);
        drain();

        // Backpressure: hold DONE for 5 cycles while new operands are offered.
        out_ready = 1'b0;
        send(8'h12, 8'h34, 2'b01, 8'h26, 3, 1'b0);
        n = 0;
        while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
        check("bp_reached_done", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            a = 8'hFF; b = 8'h00; mode = 2'b00; in_valid = (i % 2 == 0);
            @(posedge clk); #1;
            check("bp_result", 32'(result), 32'h26);
            check("bp_count", 32'(count), 32'd3);
            check("bp_all_ones", 32'(all_ones), 32'd0);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        check("bp_release_out_valid", 32'(out_valid), 32'd0);
        repeat (3) begin
            @(posedge clk); #1;
            check("bp_stays_idle", 32'(in_ready), 32'd1);
        end

        // Asynchronous reset three cycles into BUSY.
        send(8'hA5, 8'h5A, 2'b00, 8'h00, 0, 1'b0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_result", 32'(result), 32'd0);
        check("arst_count", 32'(count), 32'd0);
        check("arst_all_ones", 32'(all_ones), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("arst_no_out_valid", 32'(seen), 32'd0);
        send(8'h00, 8'h00, 2'b10, 8'hFF, 8, 1'b1);
        drain();

        // CHUNK=4 instance: two chunks per transaction.
        send4(8'h3C, 8'h3C, 2'b00, 8'hFF, 8, 1'b1);
        send4(8'h3C, 8'h3C, 2'b00, 8'hFF, 8, 1'b1);
        drain4();
`ifdef XNOR_MATCH_ACCUM_EN
        check("accum_sum", 32'(accum_4), 32'd16);
        accum_clr_4 = 1'b1;
        @(posedge clk); #1;
        accum_clr_4 = 1'b0;
        check("accum_clr", 32'(accum_4), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
